candidate_gen: RTL and testbench

//  Enumerates every NUM_DIGITS-long decimal candidate string, "00..0" through "99..9", in ASCII.

---
 rtl/candidate_gen_pkg.sv | 21 ++
 rtl/candidate_gen_if.sv | 22 ++
 rtl/candidate_gen_digit_cell.sv | 38 +++
 rtl/candidate_gen.sv | 127 ++++++++++++
 tb/tb_candidate_gen.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/candidate_gen_pkg.sv
// Shared constants and state encoding for the decimal candidate generator.
// Optional feature macro used by the top level: CANDGEN_COUNT_EN (candidate index counter).
package candgen_pkg;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [3:0] BCD_MAX    = 4'd9;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

   // A BCD digit maps onto '0'..'9' by replacing the low nibble of ASCII '0'.
   function automatic logic [7:0] bcd_to_ascii(input logic [3:0] bcd);
      logic [7:0] zero;
      zero = ASCII_ZERO;
      return {zero[7:4], bcd};
   endfunction

endpackage

// File: rtl/candidate_gen_if.sv
// Candidate stream from the generator to the hash/compare core (valid/ready handshake).
interface candidate_gen_if #(
   parameter int NUM_DIGITS = 6
);

   logic [8*NUM_DIGITS-1:0] cand_data;
   logic                    cand_valid;
   logic                    cand_ready;

   modport master (
      output cand_data,
      output cand_valid,
      input  cand_ready
   );

   modport slave (
      input  cand_data,
      input  cand_valid,
      output cand_ready
   );

endinterface

// File: rtl/candidate_gen_digit_cell.sv
// One decimal digit of the candidate: a BCD register that counts 0..9 when enabled,
// wraps to 0 and raises a combinational carry when it is at 9 while enabled.
module candgen_digit_cell
   import candgen_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       en,
   output logic [7:0] ascii,
   output logic       carry
);

   logic [3:0] bcd_q;
   logic [3:0] bcd_d;

   always_comb begin
      bcd_d = bcd_q;
      if (clear) begin
         bcd_d = 4'd0;
      end else if (en) begin
         // Anything at or above 9 wraps, so an illegal code can never persist.
         bcd_d = (bcd_q >= BCD_MAX) ? 4'd0 : bcd_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bcd_q <= 4'd0;
      end else begin
         bcd_q <= bcd_d;
      end
   end

   assign carry = en && (bcd_q == BCD_MAX);
   assign ascii = bcd_to_ascii(bcd_q);

endmodule

// File: rtl/candidate_gen.sv
// Enumerates all NUM_DIGITS-long decimal strings in ASCII, one per accepted handshake.
// Define CANDGEN_COUNT_EN to add the cand_index counter port (COUNT_W bits).
module candidate_gen
   import candgen_pkg::*;
#(
   parameter int NUM_DIGITS = 6
`ifdef CANDGEN_COUNT_EN
   ,
   parameter int COUNT_W    = 32
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   candidate_gen_if.master     cand_if,
   output logic                busy,
   output logic                done
`ifdef CANDGEN_COUNT_EN
   ,
   output logic [COUNT_W-1:0]  cand_index
`endif
);

   state_t state_q;
   state_t state_d;

   logic [NUM_DIGITS-1:0]   digit_en;
   logic [NUM_DIGITS-1:0]   digit_carry;
   logic [8*NUM_DIGITS-1:0] digit_ascii;

   logic handshake;
   logic clear_digits;
   logic space_wrap;

   assign handshake    = cand_if.cand_valid && cand_if.cand_ready;
   // Carry out of the top digit means the all-'9' candidate was just accepted.
   assign space_wrap   = digit_carry[NUM_DIGITS-1];
   // Start is only honoured outside RUN, and abort in the same cycle suppresses it.
   assign clear_digits = (state_q != RUN) && start && !abort;

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         if (gi == 0) begin : g_lsd
            assign digit_en[gi] = handshake;
         end else begin : g_upper
            assign digit_en[gi] = digit_carry[gi-1];
         end

         candgen_digit_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .clear (clear_digits),
            .en    (digit_en[gi]),
            .ascii (digit_ascii[8*gi +: 8]),
            .carry (digit_carry[gi])
         );
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = RUN;
            end
         end
         RUN: begin
            // A handshake in the abort cycle still advances the digits, but abort wins the state.
            if (abort) begin
               state_d = IDLE;
            end else if (space_wrap) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (abort) begin
               state_d = IDLE;
            end else if (start) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign cand_if.cand_data  = digit_ascii;
   assign cand_if.cand_valid = (state_q == RUN);
   assign busy               = (state_q == RUN);
   assign done               = (state_q == DONE);

`ifdef CANDGEN_COUNT_EN
   logic [COUNT_W-1:0] cand_index_q;
   logic [COUNT_W-1:0] cand_index_d;

   always_comb begin
      cand_index_d = cand_index_q;
      if (clear_digits) begin
         cand_index_d = '0;
      end else if (handshake) begin
         cand_index_d = cand_index_q + COUNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cand_index_q <= '0;
      end else begin
         cand_index_q <= cand_index_d;
      end
   end

   assign cand_index = cand_index_q;
`endif

endmodule

// File: tb/tb_candidate_gen.sv
// Scoreboard bench for candidate_gen: a two-digit and a one-digit instance side by side.
module tb_candidate_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst2, start2, abort2, busy2, done2;
   logic rst1, start1, abort1, busy1, done1;

   candidate_gen_if #(.NUM_DIGITS(2)) if2 ();
   candidate_gen_if #(.NUM_DIGITS(1)) if1 ();

`ifdef CANDGEN_COUNT_EN
   logic [7:0] idx2;
   logic [3:0] idx1;
`endif

   candidate_gen #(
      .NUM_DIGITS(2)
`ifdef CANDGEN_COUNT_EN
      , .COUNT_W(8)
`endif
   ) dut2 (
      .clk     (clk),
      .rst     (rst2),
      .start   (start2),
      .abort   (abort2),
      .cand_if (if2),
      .busy    (busy2),
      .done    (done2)
`ifdef CANDGEN_COUNT_EN
      , .cand_index (idx2)
`endif
   );

   candidate_gen #(
      .NUM_DIGITS(1)
`ifdef CANDGEN_COUNT_EN
      , .COUNT_W(4)
`endif
   ) dut1 (
      .clk     (clk),
      .rst     (rst1),
      .start   (start1),
      .abort   (abort1),
      .cand_if (if1),
      .busy    (busy1),
      .done    (done1)
`ifdef CANDGEN_COUNT_EN
      , .cand_index (idx1)
`endif
   );

   int pass_cnt  = 0;
   int total_cnt = 0;
   int exp_q[$];

   function automatic logic [15:0] enc2(input int n);
      return {4'h3, 4'(n / 10), 4'h3, 4'(n % 10)};
   endfunction

   function automatic logic [7:0] enc1(input int n);
      return {4'h3, 4'(n)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst2 = 1'b1; rst1 = 1'b1;
      start2 = 1'b0; abort2 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
      if2.cand_ready = 1'b0; if1.cand_ready = 1'b0;
      repeat (3) tick();
      rst2 = 1'b0; rst1 = 1'b0;
      tick();
      total_cnt++;
      if (if2.cand_data !== 16'h3030) $display("FAIL reset_data2 got=%h exp=3030", if2.cand_data);
      else pass_cnt++;
      total_cnt++;
      if (if2.cand_valid !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0)
         $display("FAIL reset_flags2 got valid=%b busy=%b done=%b exp=0,0,0", if2.cand_valid, busy2, done2);
      else pass_cnt++;
      total_cnt++;
      if (if1.cand_data !== 8'h30 || if1.cand_valid !== 1'b0 || done1 !== 1'b0)
         $display("FAIL reset_dut1 got data=%h valid=%b done=%b exp=30,0,0", if1.cand_data, if1.cand_valid, done1);
      else pass_cnt++;
`ifdef CANDGEN_COUNT_EN
      total_cnt++;
      if (idx2 !== 8'd0 || idx1 !== 4'd0) $display("FAIL reset_index got=%0d/%0d exp=0/0", idx2, idx1);
      else pass_cnt++;
`endif
   endtask

   task automatic test_full_sweep();
      int cycles = 0;
      int v;
      start2 = 1'b1;
      for (int n = 0; n < 100; n++) exp_q.push_back(n);
      tick();
      start2 = 1'b0;
      if2.cand_ready = 1'b1;
      while (exp_q.size() > 0 && cycles < 300) begin
         if (if2.cand_valid && if2.cand_ready) begin
            v = exp_q.pop_front();
            $display("txn sweep data=%h exp=%h", if2.cand_data, enc2(v));
            total_cnt++;
            if (if2.cand_data !== enc2(v)) $display("FAIL sweep_data got=%h exp=%h", if2.cand_data, enc2(v));
            else pass_cnt++;
`ifdef CANDGEN_COUNT_EN
            total_cnt++;
            if (idx2 !== 8'(v)) $display("FAIL sweep_index got=%0d exp=%0d", idx2, v);
            else pass_cnt++;
`endif
            if (v == 0) begin
               total_cnt++;
               if (busy2 !== 1'b1) $display("FAIL sweep_busy got=%b exp=1", busy2);
               else pass_cnt++;
            end
         end
         tick();
         cycles++;
      end
      if2.cand_ready = 1'b0;
      total_cnt++;
      if (cycles !== 100 || exp_q.size() != 0)
         $display("FAIL sweep_cycles got=%0d left=%0d exp=100 left=0", cycles, exp_q.size());
      else pass_cnt++;
      total_cnt++;
      if (done2 !== 1'b1 || if2.cand_valid !== 1'b0 || busy2 !== 1'b0)
         $display("FAIL sweep_end got done=%b valid=%b busy=%b exp=1,0,0", done2, if2.cand_valid, busy2);
      else pass_cnt++;
      total_cnt++;
      if (if2.cand_data !== 16'h3030) $display("FAIL sweep_wrap got=%h exp=3030", if2.cand_data);
      else pass_cnt++;
      exp_q.delete();
   endtask

   task automatic test_backpressure();
      int cycles = 0;
      int v;
      logic held = 1'b0;
      logic [15:0] held_data = '0;
      start2 = 1'b1;
      for (int n = 0; n < 100; n++) exp_q.push_back(n);
      tick();
      start2 = 1'b0;
      total_cnt++;
      if (done2 !== 1'b0 || if2.cand_valid !== 1'b1)
         $display("FAIL bp_restart got done=%b valid=%b exp=0,1", done2, if2.cand_valid);
      else pass_cnt++;
      while (exp_q.size() > 0 && cycles < 2000) begin
         if2.cand_ready = 1'($urandom_range(0, 1));
         if (held && if2.cand_valid) begin
            total_cnt++;
            if (if2.cand_data !== held_data) $display("FAIL bp_stable got=%h exp=%h", if2.cand_data, held_data);
            else pass_cnt++;
         end
         if (if2.cand_valid && if2.cand_ready) begin
            v = exp_q.pop_front();
            $display("txn bp data=%h exp=%h", if2.cand_data, enc2(v));
            total_cnt++;
            if (if2.cand_data !== enc2(v)) $display("FAIL bp_data got=%h exp=%h", if2.cand_data, enc2(v));
            else pass_cnt++;
            held = 1'b0;
         end else if (if2.cand_valid) begin
            held = 1'b1;
            held_data = if2.cand_data;
         end
         tick();
         cycles++;
      end
      if2.cand_ready = 1'b0;
      total_cnt++;
      if (exp_q.size() != 0 || done2 !== 1'b1)
         $display("FAIL bp_end got left=%0d done=%b exp=0,1", exp_q.size(), done2);
      else pass_cnt++;
      exp_q.delete();
   endtask

   task automatic test_abort();
      int cycles = 0;
      int v;
      start2 = 1'b1;
      for (int n = 0; n < 37; n++) exp_q.push_back(n);
      tick();
      start2 = 1'b0;
      if2.cand_ready = 1'b1;
      while (exp_q.size() > 0 && cycles < 100) begin
         if (if2.cand_valid && if2.cand_ready) begin
            v = exp_q.pop_front();
            $display("txn abort_run data=%h exp=%h", if2.cand_data, enc2(v));
            total_cnt++;
            if (if2.cand_data !== enc2(v)) $display("FAIL abort_run_data got=%h exp=%h", if2.cand_data, enc2(v));
            else pass_cnt++;
         end
         tick();
         cycles++;
      end
      if2.cand_ready = 1'b0;
      abort2 = 1'b1;
      tick();
      abort2 = 1'b0;
      total_cnt++;
      if (if2.cand_valid !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0)
         $display("FAIL abort_idle got valid=%b busy=%b done=%b exp=0,0,0", if2.cand_valid, busy2, done2);
      else pass_cnt++;
      total_cnt++;
      if (if2.cand_data !== enc2(37)) $display("FAIL abort_hold got=%h exp=%h", if2.cand_data, enc2(37));
      else pass_cnt++;
`ifdef CANDGEN_COUNT_EN
      total_cnt++;
      if (idx2 !== 8'd37) $display("FAIL abort_index got=%0d exp=37", idx2);
      else pass_cnt++;
`endif
      start2 = 1'b1; abort2 = 1'b1;
      tick();
      start2 = 1'b0; abort2 = 1'b0;
      tick();
      total_cnt++;
      if (if2.cand_valid !== 1'b0 || busy2 !== 1'b0 || if2.cand_data !== enc2(37))
         $display("FAIL start_abort got valid=%b busy=%b data=%h exp=0,0,%h", if2.cand_valid, busy2, if2.cand_data, enc2(37));
      else pass_cnt++;
      // Restart at "00"; abort lands on the cycle that also accepts "05".
      start2 = 1'b1;
      for (int n = 0; n < 6; n++) exp_q.push_back(n);
      tick();
      start2 = 1'b0;
      if2.cand_ready = 1'b1;
      cycles = 0;
      while (exp_q.size() > 0 && cycles < 50) begin
         if (exp_q.size() == 1) abort2 = 1'b1;
         if (if2.cand_valid && if2.cand_ready) begin
            v = exp_q.pop_front();
            $display("txn restart data=%h exp=%h", if2.cand_data, enc2(v));
            total_cnt++;
            if (if2.cand_data !== enc2(v)) $display("FAIL restart_data got=%h exp=%h", if2.cand_data, enc2(v));
            else pass_cnt++;
         end
         tick();
         cycles++;
      end
      abort2 = 1'b0;
      if2.cand_ready = 1'b0;
      total_cnt++;
      if (if2.cand_valid !== 1'b0 || if2.cand_data !== enc2(6))
         $display("FAIL abort_hs got valid=%b data=%h exp=0,%h", if2.cand_valid, if2.cand_data, enc2(6));
      else pass_cnt++;
`ifdef CANDGEN_COUNT_EN
      total_cnt++;
      if (idx2 !== 8'd6) $display("FAIL abort_hs_index got=%0d exp=6", idx2);
      else pass_cnt++;
`endif
      exp_q.delete();
   endtask

   task automatic test_rst_mid_run();
      int cycles = 0;
      int v;
      start2 = 1'b1;
      for (int n = 0; n < 10; n++) exp_q.push_back(n);
      tick();
      if2.cand_ready = 1'b1;
      while (exp_q.size() > 0 && cycles < 50) begin
         start2 = (exp_q.size() % 3 == 0);
         if (if2.cand_valid && if2.cand_ready) begin
            v = exp_q.pop_front();
            $display("txn rst_run data=%h exp=%h", if2.cand_data, enc2(v));
            total_cnt++;
            if (if2.cand_data !== enc2(v)) $display("FAIL rst_run_data got=%h exp=%h", if2.cand_data, enc2(v));
            else pass_cnt++;
         end
         tick();
         cycles++;
      end
      start2 = 1'b0;
      total_cnt++;
      if (if2.cand_data !== enc2(10) || busy2 !== 1'b1)
         $display("FAIL start_ignored got data=%h busy=%b exp=%h,1", if2.cand_data, busy2, enc2(10));
      else pass_cnt++;
      rst2 = 1'b1;
      tick();
      total_cnt++;
      if (if2.cand_data !== 16'h3030 || if2.cand_valid !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0)
         $display("FAIL rst_mid got data=%h valid=%b busy=%b done=%b exp=3030,0,0,0",
                  if2.cand_data, if2.cand_valid, busy2, done2);
      else pass_cnt++;
`ifdef CANDGEN_COUNT_EN
      total_cnt++;
      if (idx2 !== 8'd0) $display("FAIL rst_mid_index got=%0d exp=0", idx2);
      else pass_cnt++;
`endif
      rst2 = 1'b0;
      if2.cand_ready = 1'b0;
      tick();
      total_cnt++;
      if (if2.cand_valid !== 1'b0) $display("FAIL rst_after got valid=%b exp=0", if2.cand_valid);
      else pass_cnt++;
      exp_q.delete();
   endtask

   task automatic test_one_digit();
      int cycles = 0;
      int v;
      start1 = 1'b1;
      for (int n = 0; n < 10; n++) exp_q.push_back(n);
      tick();
      start1 = 1'b0;
      if1.cand_ready = 1'b1;
      while (exp_q.size() > 0 && cycles < 50) begin
         if (if1.cand_valid && if1.cand_ready) begin
            v = exp_q.pop_front();
            $display("txn one data=%h exp=%h", if1.cand_data, enc1(v));
            total_cnt++;
            if (if1.cand_data !== enc1(v)) $display("FAIL one_data got=%h exp=%h", if1.cand_data, enc1(v));
            else pass_cnt++;
`ifdef CANDGEN_COUNT_EN
            total_cnt++;
            if (idx1 !== 4'(v)) $display("FAIL one_index got=%0d exp=%0d", idx1, v);
            else pass_cnt++;
`endif
         end
         tick();
         cycles++;
      end
      if1.cand_ready = 1'b0;
      total_cnt++;
      if (cycles !== 10 || done1 !== 1'b1 || if1.cand_valid !== 1'b0 || if1.cand_data !== 8'h30)
         $display("FAIL one_end got cycles=%0d done=%b valid=%b data=%h exp=10,1,0,30",
                  cycles, done1, if1.cand_valid, if1.cand_data);
      else pass_cnt++;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      total_cnt++;
      if (done1 !== 1'b0 || if1.cand_valid !== 1'b1 || if1.cand_data !== 8'h30)
         $display("FAIL one_restart got done=%b valid=%b data=%h exp=0,1,30", done1, if1.cand_valid, if1.cand_data);
      else pass_cnt++;
`ifdef CANDGEN_COUNT_EN
      total_cnt++;
      if (idx1 !== 4'd0) $display("FAIL one_restart_index got=%0d exp=0", idx1);
      else pass_cnt++;
`endif
      abort1 = 1'b1;
      tick();
      abort1 = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst2 = 1'b1; rst1 = 1'b1;
      start2 = 1'b0; abort2 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
      if2.cand_ready = 1'b0; if1.cand_ready = 1'b0;
      tick();
      test_reset();
      test_full_sweep();
      test_backpressure();
      test_abort();
      test_rst_mid_run();
      test_one_digit();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
